// File: rtl/mem_access_seq.sv
// Memory-stage access sequencer: follows up to MAX_INDIR pointer hops through
// the data-side line memory, then performs the final word read or a
// byte-enabled word write. It holds the pipeline with stall until done.
module mem_access_seq #(
  parameter int WORD_W    = 16,
  parameter int LINE_W    = 128,
  parameter int ADDR_W    = 16,
  parameter int MAX_INDIR = 2,
  localparam int HOP_W    = (MAX_INDIR > 0) ? $clog2(MAX_INDIR + 1) : 1,
  localparam int OFF_W    = $clog2(LINE_W / 8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [HOP_W-1:0]        req_indir,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [WORD_W-1:0]       req_wdata,
  input  logic [WORD_W/8-1:0]     req_be,
  output logic                    stall,
  output logic                    rsp_valid,
  output logic [WORD_W-1:0]       rsp_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-OFF_W-1:0] mem_address,
  output logic [LINE_W-1:0]       mem_wdata,
  output logic [LINE_W/8-1:0]     mem_sel,
  input  logic [LINE_W-1:0]       mem_rdata,
  input  logic                    mem_resp
);

  localparam int BYTES_W = WORD_W / 8;
  localparam int NWORDS  = LINE_W / WORD_W;
  localparam int WSEL_LO = $clog2(BYTES_W);
  localparam int IDX_W   = OFF_W - WSEL_LO;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INDIR,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [HOP_W-1:0]    hops_q, hops_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic                write_q, write_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [BYTES_W-1:0]  be_q, be_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  // Word-sliced views of the line buses; the word index ignores the
  // sub-word byte bits of the current address.
  logic [NWORDS-1:0][WORD_W-1:0]  rdata_words;
  logic [NWORDS-1:0][BYTES_W-1:0] sel_words;
  logic [IDX_W-1:0]               word_idx;
  logic [WORD_W-1:0]              sel_word;
  logic [HOP_W-1:0]               req_hops;

  assign rdata_words = mem_rdata;
  assign word_idx    = cur_addr_q[OFF_W-1:WSEL_LO];
  assign sel_word    = rdata_words[word_idx];
  assign req_hops    = (req_indir > HOP_W'(MAX_INDIR)) ? HOP_W'(MAX_INDIR) : req_indir;

  // Next-state logic for the sequencer and its request/address registers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    hops_d     = hops_q;
    cur_addr_d = cur_addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cur_addr_d = req_addr;
          write_d    = req_write;
          wdata_d    = req_wdata;
          be_d       = req_be;
          hops_d     = req_hops;
          state_d    = (req_hops != '0) ? S_INDIR : S_ACCESS;
        end
      end
      S_INDIR: begin
        if (mem_resp) begin
          cur_addr_d = ADDR_W'(sel_word);
          hops_d     = hops_q - HOP_W'(1);
          if (hops_q == HOP_W'(1)) state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_resp) begin
          if (!write_q) rdata_d = sel_word;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hops_q     <= '0;
      cur_addr_q <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from the values before the edge.
      state_q    <= state_d;
      hops_q     <= hops_d;
      cur_addr_q <= cur_addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
    end
  end

  // Byte enables land only in the addressed word slot, and only on writes.
  always_comb begin
    sel_words = '0;
    if (state_q == S_ACCESS && write_q) sel_words[word_idx] = be_q;
  end

  // Memory-side outputs depend only on registered state.
  assign mem_read    = (state_q == S_INDIR) || (state_q == S_ACCESS && !write_q);
  assign mem_write   = (state_q == S_ACCESS) && write_q;
  assign mem_address = cur_addr_q[ADDR_W-1:OFF_W];
  assign mem_wdata   = {NWORDS{wdata_q}};
  assign mem_sel     = sel_words;

  // Pipeline handshake; stall rises in the accept cycle itself.
  assign stall     = (state_q == S_IDLE && req_valid) ||
                     (state_q == S_INDIR) || (state_q == S_ACCESS);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: a sparse word-addressed memory model answers the
// sequencer with random latency; expected addresses, enables and read data
// come from walking the pointer chain in that model.
module tb_mem_access_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_write;
  logic [1:0]   req_indir;
  logic [15:0]  req_addr, req_wdata;
  logic [1:0]   req_be;
  logic         stall, rsp_valid;
  logic [15:0]  rsp_rdata;
  logic         mem_read, mem_write;
  logic [11:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_sel;
  logic [127:0] mem_rdata;
  logic         mem_resp;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [logic [14:0]];
  logic [15:0] exp_rdata;

  mem_access_seq #(.WORD_W(16), .LINE_W(128), .ADDR_W(16), .MAX_INDIR(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_indir(req_indir),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_word(input logic [14:0] wa);
    if (mdl.exists(wa)) return mdl[wa];
    return {1'b0, wa} ^ 16'hA5C3;
  endfunction

  function automatic logic [127:0] build_line(input logic [11:0] la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = rd_word({la, 3'(w)});
    return l;
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Idle cycles with spurious responses; nothing may move.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_resp  = 1'($urandom);
      mem_rdata = rnd_line();
      #1;
      check("idle_stall", 128'(stall), 128'(0));
      check("idle_strobes", 128'({mem_read, mem_write}), 128'(0));
      check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
    end
    mem_resp = 1'b0;
  endtask

  // One full request: accept, pointer hops, final access, response pulse.
  task automatic do_req(input logic wr, input logic [1:0] indir, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input int lat);
    logic [15:0] a;
    logic [15:0] cur;
    int          hops;
    int          l;
    bit          fin;
    hops = (indir > 2'd2) ? 2 : int'(indir);
    a    = addr;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_indir = indir;
    req_addr  = addr; req_wdata = wd; req_be = be;
    mem_resp  = 1'b0;
    #1;
    check("accept_stall", 128'(stall), 128'(1));
    check("accept_strobes", 128'({mem_read, mem_write}), 128'(0));
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_indir = 2'($urandom);
    req_addr  = 16'($urandom); req_wdata = 16'($urandom); req_be = 2'($urandom);
    for (int k = 0; k <= hops; k++) begin
      fin = (k == hops);
      l   = (lat != 0) ? lat : int'($urandom_range(1, 3));
      for (int c = 0; c < l; c++) begin
        @(negedge clk);
        mem_resp  = (c == l - 1);
        mem_rdata = mem_resp ? build_line(a[15:4]) : rnd_line();
        #1;
        check("mem_read", 128'(mem_read), 128'(!(fin && wr)));
        check("mem_write", 128'(mem_write), 128'(fin && wr));
        check("mem_address", 128'(mem_address), 128'(a[15:4]));
        check("busy_stall", 128'(stall), 128'(1));
        check("busy_rsp_valid", 128'(rsp_valid), 128'(0));
        if (fin && wr) begin
          check("mem_sel", 128'(mem_sel), 128'(16'(be) << (2 * a[3:1])));
          check("mem_wdata", mem_wdata, {8{wd}});
        end else begin
          check("mem_sel_rd", 128'(mem_sel), 128'(0));
        end
      end
      if (!fin) a = rd_word(a[15:1]);
    end
    if (wr) begin
      cur = rd_word(a[15:1]);
      if (be[0]) cur[7:0]  = wd[7:0];
      if (be[1]) cur[15:8] = wd[15:8];
      mdl[a[15:1]] = cur;
    end else begin
      exp_rdata = rd_word(a[15:1]);
    end
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = rnd_line();
    #1;
    check("done_rsp_valid", 128'(rsp_valid), 128'(1));
    check("done_stall", 128'(stall), 128'(0));
    check("done_strobes", 128'({mem_read, mem_write}), 128'(0));
    check("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
    @(negedge clk);
    #1;
    check("after_rsp_valid", 128'(rsp_valid), 128'(0));
  endtask

  // Asynchronous reset in the middle of a pointer read.
  task automatic reset_mid_indir();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_indir = 2'd2;
    req_addr  = 16'h4440; req_wdata = '0; req_be = '0; mem_resp = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_mem_read", 128'(mem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_stall", 128'(stall), 128'(0));
    check("rst_mem_address", 128'(mem_address), 128'(0));
    check("rst_rsp_rdata", 128'(rsp_rdata), 128'(0));
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("post_rst_strobes", 128'({mem_read, mem_write}), 128'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_indir = '0;
    req_addr = '0; req_wdata = '0; req_be = '0; mem_rdata = '0; mem_resp = 1'b0;
    exp_rdata = '0;
    #2;
    check("reset_outputs", 128'({stall, rsp_valid, mem_read, mem_write, mem_address, mem_sel}), 128'(0));
    check("reset_wdata", mem_wdata, 128'(0));
    check("reset_rdata", 128'(rsp_rdata), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle_noise(2);

    // Directed scenarios.
    mdl[15'h091B] = 16'hBEEF;
    do_req(1'b0, 2'd0, 16'h1236, 16'h0000, 2'b00, 2);
    do_req(1'b1, 2'd0, 16'h0104, 16'hAB12, 2'b10, 1);
    mdl[15'h1800] = 16'h4002;
    mdl[15'h2001] = 16'h5555;
    do_req(1'b0, 2'd1, 16'h3000, 16'h0000, 2'b00, 1);
    mdl[15'h1000] = 16'h6010;
    mdl[15'h3008] = 16'h7006;
    do_req(1'b1, 2'd2, 16'h2000, 16'h1234, 2'b11, 1);
    do_req(1'b0, 2'd0, 16'h7006, 16'h0000, 2'b00, 1);
    reset_mid_indir();
    do_req(1'b0, 2'd0, 16'h1236, 16'h0000, 2'b00, 1);
    idle_noise(4);
    mdl[15'h0A00] = 16'h0B02;
    mdl[15'h0581] = 16'h0C04;
    mdl[15'h0602] = 16'h0D06;
    do_req(1'b0, 2'd3, 16'h1400, 16'h0000, 2'b00, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      do_req(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 0);
      if ($urandom_range(0, 2) == 0) idle_noise(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Parametrised memory-stage access sequencer for the pipelined LC-3b core, generalising the hard-wired LDI/STI double-access logic to N levels of indirection. It sits between the EX/MEM pipeline register and the data-side line memory (cache). It accepts one load/store request per instruction, walks up to MAX_INDIR pointer hops, and performs the final word read or byte-enabled write. It holds the pipeline via `stall` until the final access completes.

## Interface
Parameters:
- WORD_W, 16, data word width in bits (multiple of 8)
- LINE_W, 128, memory line width in bits (power-of-two multiple of WORD_W)
- ADDR_W, 16, byte address width; OFF_W = log2(LINE_W/8), line address = addr[ADDR_W-1:OFF_W]
- MAX_INDIR, 2, maximum pointer hops before final access (LDI/STI = 1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  EX/MEM stage holds a memory instruction
- req_write  in  1  final access is a write
- req_indir  in  clog2(MAX_INDIR+1)  number of pointer hops
- req_addr  in  ADDR_W  initial byte address
- req_wdata  in  WORD_W  store data
- req_be  in  WORD_W/8  byte enables for final write
- stall  out  1  freeze all pipeline registers and PC
- rsp_valid  out  1  one-cycle pulse: final access done
- rsp_rdata  out  WORD_W  final read word, held until next final read
- mem_read  out  1  line read strobe
- mem_write  out  1  line write strobe
- mem_address  out  ADDR_W-OFF_W  line address
- mem_wdata  out  LINE_W  write line
- mem_sel  out  LINE_W/8  per-byte write enable
- mem_rdata  in  LINE_W  read line
- mem_resp  in  1  memory access complete this cycle

## Operation
- States: IDLE, INDIR, ACCESS, DONE.
- IDLE: if req_valid, latch addr, write, wdata, be, and hops = min(req_indir, MAX_INDIR). Go to INDIR if hops>0, else ACCESS. Memory strobes are 0.
- INDIR: mem_read=1, mem_address=cur_addr line. On mem_resp, cur_addr <= word at index cur_addr[OFF_W-1:1] of mem_rdata and hops decrements. If the new hops is 0, go to ACCESS; otherwise stay in INDIR (strobe stays high, back-to-back).
- ACCESS: mem_read=~write, mem_write=write.
  - mem_wdata = wdata replicated across all LINE_W/WORD_W slots.
  - mem_sel = be placed at byte offset 2*cur_addr[OFF_W-1:1]; zero elsewhere; all zero on reads.
  - On mem_resp: reads latch the selected word into rsp_rdata. Go to DONE.
- DONE: rsp_valid=1, stall=0, and the state returns to IDLE unconditionally. The pipeline advances on this edge.
- Address bit 0 is ignored for word selection; byte lanes come only from be.
- Request inputs are ignored outside IDLE.
- mem_resp is ignored in IDLE and DONE.
- stall = (state==IDLE & req_valid) | state==INDIR | state==ACCESS.
- Reset (asynchronous, any state): state=IDLE, stall=0, rsp_valid=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_sel=0, rsp_rdata=0, hop counter=0. An in-flight memory access is abandoned.

## Timing
- Request accepted in cycle 0 (stall high the same cycle, combinationally).
- First memory strobe in cycle 1.
- Each access lasts until mem_resp; the next access strobes in the cycle after.
- Total stall cycles = 1 + sum of access durations. rsp_valid follows in the cycle after the final mem_resp.
- Minimum latency with single-cycle memory and 0 hops: stall in cycles 0–1, rsp_valid in cycle 2.
- Memory outputs are functions of registered state only; no combinational path from mem_resp or mem_rdata to strobes.

## Test plan
WORD_W=16, LINE_W=128, ADDR_W=16, MAX_INDIR=2.

1. Read, 0 hops, addr 0x1236, mem_rdata word3=0xBEEF, mem_resp 2 cycles after strobe -> mem_address=0x123, mem_read high 2 cycles, stall high 3 cycles, one rsp_valid pulse with rsp_rdata=0xBEEF.
2. Write, 0 hops, addr 0x0104, wdata 0xAB12, be=2'b10 -> mem_write=1, mem_address=0x010, mem_sel=16'h0020, mem_wdata=8 copies of 0xAB12, mem_read=0, rsp_rdata unchanged.
3. LDI (hops=1), addr 0x3000, line 0x300 word0=0x4002, line 0x400 word1=0x5555 -> reads at 0x300 then 0x400 back-to-back, rsp_rdata=0x5555.
4. STI chain (hops=2), addr 0x2000 -> 0x6010 -> 0x7006, wdata 0x1234, be=2'b11 -> reads 0x200 and 0x601, then write at 0x700 with mem_sel=16'h00C0.
5. rst_n pulled low mid-INDIR with mem_read high -> same-instant mem_read=0, stall=0, state IDLE; no rsp_valid. After release, a new 0-hop read completes normally.
6. req_indir=3 (clipped to 2), plus spurious mem_resp pulses while IDLE -> exactly 2 pointer reads then the final access; spurious responses have no effect.
